pi_spigot: RTL and testbench
============================

PI_SPIGOT -- requirements
Module: pi_spigot

Interface
REQ-001 SHALL have parameter WORD_DIGITS, default 4, meaning decimal digits per output word (legal 1..4); B = 10^WORD_DIGITS, S = ceil(10*WORD_DIGITS/3).
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning maximum words per run; remainder RAM depth is MAX_WORDS*S+1 entries of 32 bits.
REQ-003 SHALL have port clock  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port words  input  32  word count requested, latched with start.
REQ-007 SHALL have port pi_word  output  32  output word, WORD_DIGITS decimal digits of pi as a binary integer.
REQ-008 SHALL have port out_valid  output  1  pi_word valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high on a rising edge.
REQ-010 SHALL have port done  output  1  marks the final word of a run.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port error  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 SHALL implement the states IDLE, INIT, STEP, EMIT and FLUSH.
REQ-014 In IDLE with start=1, SHALL latch N=words and C=N*S, then go to INIT, but only if 1<=words<=MAX_WORDS.
REQ-015 In IDLE with start=1 and words==0 or words>MAX_WORDS, SHALL pulse error for 1 cycle, stay in IDLE and emit no words.
REQ-016 INIT SHALL write B/5 to r[1..C], one entry per cycle, and clear carry register e to 0.
REQ-017 Per word, STEP SHALL run d=0 for b=C down to 1: d+=r[b]*B; g=2b-1; r[b]=d mod g; d=d/g; if b>1, d*=b-1.
REQ-018 The d datapath SHALL be 64 bits; the divider may be multi-cycle and its latency is not specified.
REQ-019 After the STEP loop, raw word w=e+d/B SHALL be produced, e SHALL take the value d mod B, and C SHALL take the value C-S.
REQ-020 Each word SHALL pass through EMIT; out_valid SHALL be held until the transfer occurs.
REQ-021 pi_word SHALL stay stable while out_valid=1 and out_ready=0; no word SHALL be dropped or duplicated.
REQ-022 Computation of the next word SHALL not begin until the current word is transferred.
REQ-023 Exactly N words SHALL be emitted; done SHALL be high exactly while out_valid is high for word N.
REQ-024 After word N transfers, the block SHALL return to IDLE; busy SHALL fall on the next cycle.
REQ-025 start SHALL be ignored while busy.
REQ-026 The first word SHALL be the leading digits including the "3" (WORD_DIGITS=4 gives 3141).

Reset
REQ-027 reset_n low SHALL immediately force IDLE and clear pi_word, out_valid, done, busy, error, e, C and the pending counters to 0.
REQ-028 The RAM contents need not be cleared.
REQ-029 Reset mid-run SHALL abort the run with no further output; a new start SHALL be accepted after deassertion.

Configuration
REQ-030 With macro PI_CARRY_FIX_EN defined, SHALL hold back one predigit word h plus a count k of pending B-1 words.
REQ-031 Under PI_CARRY_FIX_EN, when a raw w equals B-1: k++.
REQ-032 Under PI_CARRY_FIX_EN, when w>=B: emit h+1, then k words of 0, and set h=w-B.
REQ-033 Under PI_CARRY_FIX_EN, otherwise: emit h, then k words of B-1, and set h=w.
REQ-034 Under PI_CARRY_FIX_EN, the final h and pending words SHALL drain in FLUSH, so every emitted word is below B and exactly N words total are emitted.
REQ-035 With PI_CARRY_FIX_EN undefined, raw w SHALL be emitted directly (may be >=B), with no FLUSH state and no hold-back latency.

Verification
REQ-036 WORD_DIGITS=4, words=5, out_ready=1 -> 3141,5926,5358,9793,2384; done with 2384 only; busy low afterwards.
REQ-037 WORD_DIGITS=1, words=20, PI_CARRY_FIX_EN defined -> 3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8,4.
REQ-038 Backpressure: out_ready low for 20 cycles after the first out_valid -> pi_word stays 3141 and out_valid stays high; the sequence is otherwise identical to REQ-036.
REQ-039 words=0, and words=MAX_WORDS+1 -> one-cycle error pulse each; busy stays 0; no out_valid.
REQ-040 reset_n pulsed low during the third word's STEP -> all outputs 0 at once; then start with words=2 -> 3141,5926.
REQ-041 WORD_DIGITS=4, words=MAX_WORDS, both macro settings -> every word matches the C model of REQ-017..035 bit-exactly; with the macro defined, all words are <10000.

Source files
------------

// File: rtl/pi_spigot.sv
// pi_spigot: streams decimal digits of pi, WORD_DIGITS digits per word, using the
// Rabinowitz-Wagon spigot (Winter's base-10^k form) over a 32-bit remainder RAM.
// The 64-bit long division is iterative, 4 quotient bits per cycle.
// Optional feature macro: PI_CARRY_FIX_EN -- holds back one predigit word plus a run of
// all-nines words so late carries are folded in before emission (adds the FLUSH state).
module pi_spigot #(
    parameter int unsigned WORD_DIGITS = 4,
    parameter int unsigned MAX_WORDS   = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] words,
    output logic [31:0] pi_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic        busy,
    output logic        error
);

    localparam int unsigned B = (WORD_DIGITS == 1) ? 10 :
                                (WORD_DIGITS == 2) ? 100 :
                                (WORD_DIGITS == 3) ? 1000 : 10000;
    localparam int unsigned S        = (10 * WORD_DIGITS + 2) / 3;
    localparam int unsigned DEPTH    = MAX_WORDS * S + 1;
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] B32      = 32'(B);
    localparam logic [63:0] B64      = 64'(B);
    localparam logic [31:0] S32      = 32'(S);
    localparam logic [31:0] INIT_VAL = 32'(B / 5);
    localparam logic [31:0] MAXW32   = 32'(MAX_WORDS);
    localparam int          DIV_RADIX = 4;
    localparam logic [3:0]  DIV_LAST  = 4'(64 / DIV_RADIX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StStep,
        StEmit
`ifdef PI_CARRY_FIX_EN
        , StFlush
`endif
    } state_e;

    // Sub-phases of one STEP iteration: RAM read, divider load, divider run.
    typedef enum logic [1:0] {
        PhRead,
        PhLoad,
        PhDiv
    } phase_e;

    state_e      state_q, state_d;
    phase_e      ph_q, ph_d;
    logic [31:0] out_left_q, out_left_d;   // words still to be transferred
    logic [31:0] c_q, c_d;
    logic [31:0] b_q, b_d;
    logic [31:0] init_idx_q, init_idx_d;
    logic [63:0] d_q, d_d;
    logic [31:0] e_q, e_d;
    logic [31:0] pi_word_q, pi_word_d;
    logic        error_q, error_d;

    logic [31:0] div_rem_q, div_rem_d;
    logic [63:0] div_quo_q, div_quo_d;
    logic [31:0] div_den_q, div_den_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic        div_word_q, div_word_d;    // dividing by B for the word split

`ifdef PI_CARRY_FIX_EN
    logic [31:0] h_q, h_d;
    logic [31:0] k_q, k_d;
    logic        have_h_q, have_h_d;
    logic [31:0] pend_q, pend_d;            // queued fill words behind the current one
    logic [31:0] fill_q, fill_d;
`endif

    logic [31:0] ram_q [DEPTH];
    logic [31:0] ram_rdata_q;
    logic        ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;

    logic [31:0] rem_n;
    logic [63:0] quo_n;
    logic [32:0] rem_sh;
    logic [31:0] raw_w;
    logic [31:0] c_dec;

    // Remainder RAM: single port, registered read, contents not reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[ram_addr] <= ram_wdata;
        end
        ram_rdata_q <= ram_q[ram_addr];
    end

    // Restoring divider: DIV_RADIX quotient bits per cycle from the current state.
    always_comb begin
        rem_n  = div_rem_q;
        quo_n  = div_quo_q;
        rem_sh = '0;
        for (int i = 0; i < DIV_RADIX; i++) begin
            rem_sh = {rem_n, quo_n[63]};
            quo_n  = {quo_n[62:0], 1'b0};
            if (rem_sh >= {1'b0, div_den_q}) begin
                rem_sh   = rem_sh - {1'b0, div_den_q};
                quo_n[0] = 1'b1;
            end
            rem_n = rem_sh[31:0];
        end
    end

    // Next-state logic for the control FSM and datapath.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        out_left_d = out_left_q;
        c_d        = c_q;
        b_d        = b_q;
        init_idx_d = init_idx_q;
        d_d        = d_q;
        e_d        = e_q;
        pi_word_d  = pi_word_q;
        error_d    = 1'b0;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_den_d  = div_den_q;
        div_cnt_d  = div_cnt_q;
        div_word_d = div_word_q;
`ifdef PI_CARRY_FIX_EN
        h_d        = h_q;
        k_d        = k_q;
        have_h_d   = have_h_q;
        pend_d     = pend_q;
        fill_d     = fill_q;
`endif
        ram_we     = 1'b0;
        ram_addr   = b_q[AW-1:0];
        ram_wdata  = '0;
        raw_w      = e_q + quo_n[31:0];
        c_dec      = c_q - S32;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (words != '0 && words <= MAXW32) begin
                        out_left_d = words;
                        c_d        = words * S32;
                        init_idx_d = 32'd1;
                        e_d        = '0;
                        state_d    = StInit;
`ifdef PI_CARRY_FIX_EN
                        have_h_d   = 1'b0;
                        k_d        = '0;
                        pend_d     = '0;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            StInit: begin
                ram_addr  = init_idx_q[AW-1:0];
                ram_we    = 1'b1;
                ram_wdata = INIT_VAL;
                if (init_idx_q == c_q) begin
                    state_d = StStep;
                    ph_d    = PhRead;
                    b_d     = c_q;
                    d_d     = '0;
                end else begin
                    init_idx_d = init_idx_q + 32'd1;
                end
            end

            StStep: begin
                unique case (ph_q)
                    PhRead: ph_d = PhLoad;
                    PhLoad: begin
                        div_quo_d  = d_q + ({32'd0, ram_rdata_q} * B64);
                        div_rem_d  = '0;
                        div_den_d  = {b_q[30:0], 1'b0} - 32'd1;
                        div_cnt_d  = '0;
                        div_word_d = 1'b0;
                        ph_d       = PhDiv;
                    end
                    PhDiv: begin
                        div_rem_d = rem_n;
                        div_quo_d = quo_n;
                        div_cnt_d = div_cnt_q + 4'd1;
                        if (div_cnt_q == DIV_LAST) begin
                            if (!div_word_q) begin
                                ram_we    = 1'b1;
                                ram_wdata = rem_n;
                                if (b_q > 32'd1) begin
                                    d_d  = quo_n * {32'd0, b_q - 32'd1};
                                    b_d  = b_q - 32'd1;
                                    ph_d = PhRead;
                                end else begin
                                    // Inner loop finished: split d into word and carry.
                                    div_quo_d  = quo_n;
                                    div_rem_d  = '0;
                                    div_den_d  = B32;
                                    div_cnt_d  = '0;
                                    div_word_d = 1'b1;
                                end
                            end else begin
                                e_d = rem_n;
                                c_d = c_dec;
`ifdef PI_CARRY_FIX_EN
                                if (!have_h_q || raw_w == B32 - 32'd1) begin
                                    if (!have_h_q) begin
                                        h_d      = raw_w;
                                        have_h_d = 1'b1;
                                    end else begin
                                        k_d = k_q + 32'd1;
                                    end
                                    if (c_dec == '0) begin
                                        state_d   = StFlush;
                                        pi_word_d = have_h_q ? h_q : raw_w;
                                    end else begin
                                        b_d  = c_dec;
                                        d_d  = '0;
                                        ph_d = PhRead;
                                    end
                                end else if (raw_w >= B32) begin
                                    pi_word_d = h_q + 32'd1;
                                    fill_d    = '0;
                                    pend_d    = k_q;
                                    k_d       = '0;
                                    h_d       = raw_w - B32;
                                    state_d   = StEmit;
                                end else begin
                                    pi_word_d = h_q;
                                    fill_d    = B32 - 32'd1;
                                    pend_d    = k_q;
                                    k_d       = '0;
                                    h_d       = raw_w;
                                    state_d   = StEmit;
                                end
`else
                                pi_word_d = raw_w;
                                state_d   = StEmit;
`endif
                            end
                        end
                    end
                    default: ph_d = PhRead;
                endcase
            end

            StEmit: begin
                if (out_ready) begin
                    out_left_d = out_left_q - 32'd1;
                    if (out_left_q == 32'd1) begin
                        state_d = StIdle;
`ifdef PI_CARRY_FIX_EN
                    end else if (pend_q != '0) begin
                        pi_word_d = fill_q;
                        pend_d    = pend_q - 32'd1;
                    end else if (c_q == '0) begin
                        state_d   = StFlush;
                        pi_word_d = h_q;
`endif
                    end else begin
                        state_d = StStep;
                        ph_d    = PhRead;
                        b_d     = c_q;
                        d_d     = '0;
                    end
                end
            end

`ifdef PI_CARRY_FIX_EN
            StFlush: begin
                // Drain the held predigit, then the pending all-nines words.
                if (out_ready) begin
                    out_left_d = out_left_q - 32'd1;
                    if (out_left_q == 32'd1) begin
                        state_d = StIdle;
                    end else begin
                        pi_word_d = B32 - 32'd1;
                    end
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ph_q       <= PhRead;
            out_left_q <= '0;
            c_q        <= '0;
            b_q        <= '0;
            init_idx_q <= '0;
            d_q        <= '0;
            e_q        <= '0;
            pi_word_q  <= '0;
            error_q    <= 1'b0;
            div_rem_q  <= '0;
            div_quo_q  <= '0;
            div_den_q  <= '0;
            div_cnt_q  <= '0;
            div_word_q <= 1'b0;
`ifdef PI_CARRY_FIX_EN
            h_q        <= '0;
            k_q        <= '0;
            have_h_q   <= 1'b0;
            pend_q     <= '0;
            fill_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            out_left_q <= out_left_d;
            c_q        <= c_d;
            b_q        <= b_d;
            init_idx_q <= init_idx_d;
            d_q        <= d_d;
            e_q        <= e_d;
            pi_word_q  <= pi_word_d;
            error_q    <= error_d;
            div_rem_q  <= div_rem_d;
            div_quo_q  <= div_quo_d;
            div_den_q  <= div_den_d;
            div_cnt_q  <= div_cnt_d;
            div_word_q <= div_word_d;
`ifdef PI_CARRY_FIX_EN
            h_q        <= h_d;
            k_q        <= k_d;
            have_h_q   <= have_h_d;
            pend_q     <= pend_d;
            fill_q     <= fill_d;
`endif
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
`ifdef PI_CARRY_FIX_EN
        out_valid = (state_q == StEmit) || (state_q == StFlush);
`else
        out_valid = (state_q == StEmit);
`endif
        done    = out_valid && (out_left_q == 32'd1);
        busy    = (state_q != StIdle);
        error   = error_q;
        pi_word = pi_word_q;
    end

endmodule

// File: tb/tb_pi_spigot.sv
// tb_pi_spigot: directed checks of pi_spigot (WORD_DIGITS=4, MAX_WORDS=8 instance and a
// WORD_DIGITS=1 instance), with a software reference of the spigot for the long runs.
module tb_pi_spigot;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] words;
    logic [31:0] pi_word;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        busy;
    logic        error;

    logic        start1;
    logic [31:0] words1;
    logic [31:0] pi_word1;
    logic        out_valid1;
    logic        ready1;
    logic        done1;
    logic        busy1;
    logic        error1;

    int total = 0;
    int bad   = 0;

    logic [31:0]     got_q[$];
    bit              done_q[$];
    longint unsigned exp_q[$];
    int              stray;

    int unsigned exp36 [5] = '{3141, 5926, 5358, 9793, 2384};
`ifdef PI_CARRY_FIX_EN
    int unsigned dig20 [20] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8, 9, 7, 9, 3, 2, 3, 8, 4};
`endif

    always #5 clock = ~clock;

    pi_spigot #(.WORD_DIGITS(4), .MAX_WORDS(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .words     (words),
        .pi_word   (pi_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .busy      (busy),
        .error     (error)
    );

    pi_spigot #(.WORD_DIGITS(1), .MAX_WORDS(20)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start1),
        .words     (words1),
        .pi_word   (pi_word1),
        .out_valid (out_valid1),
        .out_ready (ready1),
        .done      (done1),
        .busy      (busy1),
        .error     (error1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] n);
        @(negedge clock);
        words = n;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Record transfers of the main instance, starting with the current negedge.
    task automatic collect(input string tag, input int n, input int budget);
        int cyc = 0;
        got_q.delete();
        done_q.delete();
        stray = 0;
        while (got_q.size() < n && cyc < budget) begin
            if (done && !out_valid) stray++;
            if (out_valid && out_ready) begin
                got_q.push_back(pi_word);
                done_q.push_back(done);
            end
            @(negedge clock);
            cyc++;
        end
        check({tag, "_count"}, 64'(got_q.size()), 64'(n));
        check({tag, "_stray_done"}, 64'(stray), 64'd0);
    endtask

    task automatic collect1(input string tag, input int n, input int budget);
        int cyc = 0;
        got_q.delete();
        done_q.delete();
        stray = 0;
        while (got_q.size() < n && cyc < budget) begin
            if (done1 && !out_valid1) stray++;
            if (out_valid1 && ready1) begin
                got_q.push_back(pi_word1);
                done_q.push_back(done1);
            end
            @(negedge clock);
            cyc++;
        end
        check({tag, "_count"}, 64'(got_q.size()), 64'(n));
        check({tag, "_stray_done"}, 64'(stray), 64'd0);
    endtask

    task automatic cmp_run(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_word%0d", tag, i), {32'd0, got_q[i]}, exp_q[i]);
                check($sformatf("%s_done%0d", tag, i), {63'd0, done_q[i]},
                      (i == exp_q.size() - 1) ? 64'd1 : 64'd0);
            end
        end
    endtask

    // Reference spigot in plain integer arithmetic.
    task automatic build_model(input longint unsigned bb, input int unsigned ss,
                               input int unsigned n);
        longint unsigned r[];
        longint unsigned d, g, w, e;
        int unsigned     c;
`ifdef PI_CARRY_FIX_EN
        longint unsigned h, k;
        bit              have_h;
        h = 0;
        k = 0;
        have_h = 1'b0;
`endif
        exp_q.delete();
        c = n * ss;
        r = new[c + 1];
        for (int unsigned i = 0; i <= c; i++) r[i] = bb / 5;
        e = 0;
        while (c > 0) begin
            d = 0;
            for (int b = int'(c); b >= 1; b--) begin
                d = d + r[b] * bb;
                g = 64'(2 * b - 1);
                r[b] = d % g;
                d = d / g;
                if (b > 1) d = d * 64'(b - 1);
            end
            w = e + d / bb;
            e = d % bb;
            c = c - ss;
`ifdef PI_CARRY_FIX_EN
            if (!have_h) begin
                h = w;
                have_h = 1'b1;
            end else if (w == bb - 1) begin
                k++;
            end else if (w >= bb) begin
                exp_q.push_back(h + 1);
                for (longint unsigned j = 0; j < k; j++) exp_q.push_back(0);
                k = 0;
                h = w - bb;
            end else begin
                exp_q.push_back(h);
                for (longint unsigned j = 0; j < k; j++) exp_q.push_back(bb - 1);
                k = 0;
                h = w;
            end
`else
            exp_q.push_back(w);
`endif
        end
`ifdef PI_CARRY_FIX_EN
        exp_q.push_back(h);
        for (longint unsigned j = 0; j < k; j++) exp_q.push_back(bb - 1);
`endif
    endtask

    initial begin
        int hold_bad;
        int seen;
        int cyc;

        reset_n   = 1'b0;
        start     = 1'b0;
        words     = '0;
        out_ready = 1'b1;
        start1    = 1'b0;
        words1    = '0;
        ready1    = 1'b1;
        #12;
        check("rst_pi_word", {32'd0, pi_word}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Five words, consumer always ready; a start while busy must be ignored.
        pulse_start(32'd5);
        check("basic_busy", {63'd0, busy}, 64'd1);
        words = 32'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        collect("basic", 5, 20000);
        exp_q.delete();
        foreach (exp36[i]) exp_q.push_back(exp36[i]);
        cmp_run("basic");
        check("basic_busy_after", {63'd0, busy}, 64'd0);
        check("basic_valid_after", {63'd0, out_valid}, 64'd0);

        // Backpressure on the first word for 20 cycles.
        out_ready = 1'b0;
        pulse_start(32'd5);
        seen = 0;
        cyc = 0;
        while (!out_valid && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        check("bp_first_valid", {63'd0, out_valid}, 64'd1);
        hold_bad = 0;
        repeat (20) begin
            if (!out_valid || pi_word !== 32'd3141 || done) hold_bad++;
            @(negedge clock);
        end
        check("bp_hold", 64'(hold_bad), 64'd0);
        check("bp_word", {32'd0, pi_word}, 64'd3141);
        out_ready = 1'b1;
        collect("bp", 5, 20000);
        cmp_run("bp");
        check("bp_busy_after", {63'd0, busy}, 64'd0);

        // Rejected requests.
        pulse_start(32'd0);
        check("err0_pulse", {63'd0, error}, 64'd1);
        check("err0_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        check("err0_clear", {63'd0, error}, 64'd0);
        pulse_start(32'd9);
        check("err9_pulse", {63'd0, error}, 64'd1);
        check("err9_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clock);
            if (out_valid || busy || error) seen++;
        end
        check("err_quiet", 64'(seen), 64'd0);

        // Reset during the third word's STEP, then a fresh two-word run.
        pulse_start(32'd5);
        collect("pre_rst", 2, 20000);
        repeat (30) @(negedge clock);
        check("mid_busy", {63'd0, busy}, 64'd1);
        check("mid_valid", {63'd0, out_valid}, 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_pi_word", {32'd0, pi_word}, 64'd0);
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_error", {63'd0, error}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid || busy) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        pulse_start(32'd2);
        collect("rerun", 2, 20000);
        exp_q.delete();
        exp_q.push_back(3141);
        exp_q.push_back(5926);
        cmp_run("rerun");

        // Maximum-length run against the reference.
        build_model(64'd10000, 14, 8);
        pulse_start(32'd8);
        collect("max", 8, 40000);
        cmp_run("max");
`ifdef PI_CARRY_FIX_EN
        for (int i = 0; i < got_q.size(); i++) begin
            check($sformatf("max_lt_b%0d", i), {63'd0, (got_q[i] < 32'd10000)}, 64'd1);
        end
`endif

        // Single-digit words on the second instance.
        @(negedge clock);
        words1 = 32'd20;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        check("d1_busy", {63'd0, busy1}, 64'd1);
`ifdef PI_CARRY_FIX_EN
        exp_q.delete();
        foreach (dig20[i]) exp_q.push_back(dig20[i]);
`else
        build_model(64'd10, 4, 20);
`endif
        collect1("d1", 20, 40000);
        cmp_run("d1");
        check("d1_busy_after", {63'd0, busy1}, 64'd0);
        check("d1_error", {63'd0, error1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
